// File: rtl/pkt_tx_builder.sv
// pkt_tx_builder: assembles heartbeat, CH-announce and data packets from node state and streams them as 16-bit words.
// Latency: first header word one cycle after acceptance (data packets: one cycle after slot_active is seen); tx_done one cycle after the last word.
// Backpressure: tx_valid/tx_ready handshake; header words held until accepted; payload passes straight through (pay_ready = tx_ready in SEND_PAY).
//
// Ports:
//   clk, nrst                      clock (rising edge) and synchronous active-low reset
//   tx_req, tx_type, tx_dest,
//   tx_len                         packet request; only sampled in IDLE
//   myNodeID, hopsFromSink,
//   myQValue, energy, e_max,
//   e_min, role, low_E             node state, captured when a request is accepted
//   slot_active                    TDMA slot gate for data packets
//   pay_data, pay_valid, pay_ready payload source stream (data packets only)
//   tx_data, tx_valid, tx_last,
//   tx_ready                       outgoing word stream
//   busy, tx_done, tx_err          status; tx_done/tx_err are one-cycle pulses
module pkt_tx_builder #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        tx_req,
  input  logic [2:0]  tx_type,
  input  logic [15:0] tx_dest,
  input  logic [3:0]  tx_len,
  input  logic [15:0] myNodeID,
  input  logic [15:0] hopsFromSink,
  input  logic [15:0] myQValue,
  input  logic [15:0] energy,
  input  logic [15:0] e_max,
  input  logic [15:0] e_min,
  input  logic        role,
  input  logic        low_E,
  input  logic        slot_active,
  input  logic [15:0] pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_err
);

  localparam logic [2:0] TYPE_HB   = 3'b000;
  localparam logic [2:0] TYPE_CH   = 3'b001;
  localparam logic [2:0] TYPE_DATA = 3'b101;

  localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);

  // Index of the final header word for each packet kind.
  localparam logic [2:0] HB_LAST       = 3'd4;
  localparam logic [2:0] CH_LAST       = 3'd3;
  localparam logic [2:0] DATA_HDR_LAST = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    SEND_HDR,
    SEND_PAY
  } state_t;

  state_t      state_q, state_d;

  // Header words are built at acceptance time, so the packet in flight is
  // immune to later changes on the node-state inputs.
  logic [15:0] hdr_q [5];
  logic [15:0] hdr_d [5];
  logic [2:0]  hdr_last_q, hdr_last_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic        is_data_q, is_data_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  pay_cnt_q, pay_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic [15:0] hops_sat;
  logic [15:0] w0;
  logic        hdr_at_last;
  logic        pay_at_last;

  // Request legality: unknown types, CH announce from a non-CH node and
  // out-of-range data lengths are all rejected.
  always_comb begin
    req_ok = 1'b0;
    case (tx_type)
      TYPE_HB:   req_ok = 1'b1;
      TYPE_CH:   req_ok = role;
      TYPE_DATA: req_ok = (tx_len != 4'd0) && (tx_len <= MAX_LEN_W);
      default:   req_ok = 1'b0;
    endcase
  end

  // Hop count seen by the neighbour is ours plus one, pinned at all-ones.
  assign hops_sat = (hopsFromSink == 16'hFFFF) ? 16'hFFFF : hopsFromSink + 16'd1;

  // Length field only carries meaning for data packets.
  assign w0 = {tx_type, low_E, role, 7'b0, (tx_type == TYPE_DATA) ? tx_len : 4'd0};

  assign hdr_at_last = (hdr_idx_q == hdr_last_q);
  assign pay_at_last = (pay_cnt_q == (len_q - 4'd1));

  assign tx_done = done_q;
  assign tx_err  = err_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      for (int i = 0; i < 5; i++) begin
        hdr_q[i] <= '0;
      end
      hdr_last_q <= '0;
      hdr_idx_q  <= '0;
      is_data_q  <= 1'b0;
      len_q      <= '0;
      pay_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      hdr_last_q <= hdr_last_d;
      hdr_idx_q  <= hdr_idx_d;
      is_data_q  <= is_data_d;
      len_q      <= len_d;
      pay_cnt_q  <= pay_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    hdr_last_d = hdr_last_q;
    hdr_idx_d  = hdr_idx_q;
    is_data_d  = is_data_q;
    len_d      = len_q;
    pay_cnt_d  = pay_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    tx_data    = '0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    pay_ready  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        // Also reached in the tx_done cycle, so back-to-back packets need no gap.
        if (tx_req) begin
          if (req_ok) begin
            for (int i = 0; i < 5; i++) begin
              hdr_d[i] = '0;
            end
            hdr_d[0]  = w0;
            hdr_d[1]  = myNodeID;
            hdr_idx_d = '0;
            pay_cnt_d = '0;
            is_data_d = 1'b0;
            len_d     = '0;
            case (tx_type)
              TYPE_HB: begin
                hdr_d[2]   = hops_sat;
                hdr_d[3]   = e_max;
                hdr_d[4]   = e_min;
                hdr_last_d = HB_LAST;
                state_d    = SEND_HDR;
              end
              TYPE_CH: begin
                hdr_d[2]   = myQValue;
                hdr_d[3]   = energy;
                hdr_last_d = CH_LAST;
                state_d    = SEND_HDR;
              end
              default: begin
                // Only data remains once req_ok has filtered the type.
                hdr_d[2]   = tx_dest;
                hdr_last_d = DATA_HDR_LAST;
                is_data_d  = 1'b1;
                len_d      = tx_len;
                state_d    = WAIT_SLOT;
              end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WAIT_SLOT: begin
        busy = 1'b1;
        if (slot_active) begin
          state_d = SEND_HDR;
        end
      end

      SEND_HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = hdr_q[hdr_idx_q];
        // A data packet's last word is always payload, never header.
        tx_last  = !is_data_q && hdr_at_last;
        if (tx_ready) begin
          if (hdr_at_last) begin
            if (is_data_q) begin
              state_d = SEND_PAY;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end

      SEND_PAY: begin
        // Pure pass-through; slot_active is deliberately ignored from here on.
        busy      = 1'b1;
        tx_data   = pay_data;
        tx_valid  = pay_valid;
        tx_last   = pay_valid && pay_at_last;
        pay_ready = tx_ready;
        if (pay_valid && tx_ready) begin
          if (pay_at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            pay_cnt_d = pay_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pkt_tx_builder.sv
// Testbench for pkt_tx_builder: directed scenarios with literal expectations, then
// randomized requests, payload stalls, backpressure and resets against a packet-level model.
module tb_pkt_tx_builder;

  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        tx_req;
  logic [2:0]  tx_type;
  logic [15:0] tx_dest;
  logic [3:0]  tx_len;
  logic [15:0] myNodeID, hopsFromSink, myQValue, energy, e_max, e_min;
  logic        role, low_E, slot_active;
  logic [15:0] pay_data;
  logic        pay_valid, pay_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_last, tx_ready;
  logic        busy, tx_done, tx_err;

  always #5 clk = ~clk;

  pkt_tx_builder #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .nrst(nrst), .tx_req(tx_req), .tx_type(tx_type), .tx_dest(tx_dest),
    .tx_len(tx_len), .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .energy(energy), .e_max(e_max), .e_min(e_min), .role(role), .low_E(low_E),
    .slot_active(slot_active), .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Packet-level model: expected word list of the packet in flight.
  int          m_phase = 0;      // 0 no packet, 1 waiting for slot, 2 streaming
  logic [15:0] m_words[$];
  int          m_hdr_n = 0;
  int          m_k = 0;
  bit          m_done_exp = 0;
  bit          m_err_exp = 0;

  // Observation log used by the directed scenarios.
  logic [15:0] seen_q[$];
  bit          seen_last_q[$];
  int          valid_cnt = 0, busy_cnt = 0, err_cnt = 0, done_cnt = 0;
  int          cyc_n = 0, done_cyc = 0, last_xfer_cyc = 0;

  // Payload source stream.
  logic [15:0] pay_src[$];
  bit          pay_auto = 0;
  bit          pay_rand = 0;
  int          rdy_mode = 0;     // 0 hold, 1 toggle, 2 random

  logic [15:0] exp_w [5];

  initial begin : paysrc
    bit took;
    pay_valid = 1'b0;
    pay_data  = 16'h0;
    forever begin
      @(negedge clk);
      took = pay_valid && pay_ready;
      @(posedge clk);
      #2;
      if (took && pay_src.size() > 0) void'(pay_src.pop_front());
      if (pay_auto) while (pay_src.size() < 20) pay_src.push_back(16'($urandom));
      if (pay_src.size() == 0) pay_valid = 1'b0;
      else if (took || !pay_valid) pay_valid = pay_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      pay_data = (pay_src.size() > 0) ? pay_src[0] : 16'h0;
    end
  end

  initial begin : cmp
    bit pv, pr, pn, fire;
    logic [15:0] pd;
    logic pl;
    int total, hops;
    int unsigned w;
    pv = 0; pr = 0; pn = 0; pd = '0; pl = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc_n++;
      chk("tx_done", tx_done, m_done_exp);
      chk("tx_err", tx_err, m_err_exp);
      if (pn && pv && !pr) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
        chk("hold_last", tx_last, pl);
      end
      total = m_words.size();
      case (m_phase)
        0: begin
          chk("idle_busy", busy, 0);
          chk("idle_valid", tx_valid, 0);
          chk("idle_pay_ready", pay_ready, 0);
          chk("idle_last", tx_last, 0);
        end
        1: begin
          chk("wait_busy", busy, 1);
          chk("wait_valid", tx_valid, 0);
          chk("wait_pay_ready", pay_ready, 0);
        end
        default: begin
          chk("send_busy", busy, 1);
          if (m_k < m_hdr_n) begin
            chk("hdr_valid", tx_valid, 1);
            chk("hdr_data", tx_data, m_words[m_k]);
            chk("hdr_last", tx_last, (m_k == total - 1));
            chk("hdr_pay_ready", pay_ready, 0);
          end else begin
            chk("pay_ready", pay_ready, tx_ready);
            chk("pay_valid_pass", tx_valid, pay_valid);
            if (pay_valid) begin
              chk("pay_data", tx_data, m_words[m_k]);
              chk("pay_last", tx_last, (m_k == total - 1));
            end
          end
        end
      endcase

      if (tx_valid) valid_cnt++;
      if (busy) busy_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done) begin done_cnt++; done_cyc = cyc_n; end
      if (tx_valid && tx_ready && nrst) begin
        seen_q.push_back(tx_data);
        seen_last_q.push_back(tx_last);
        last_xfer_cyc = cyc_n;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last; pn = nrst;

      // Advance the model with the inputs the DUT samples at the next edge.
      m_done_exp = 0;
      m_err_exp  = 0;
      if (!nrst) begin
        m_phase = 0;
        m_words.delete();
        m_k = 0;
      end else begin
        case (m_phase)
          0: if (tx_req) begin
            if ((tx_type == 3'd0) || (tx_type == 3'd1 && role) ||
                (tx_type == 3'd5 && tx_len >= 1 && int'(tx_len) <= MAXL)) begin
              m_words.delete();
              m_k = 0;
              w = tx_type * 32'h2000 + low_E * 32'h1000 + role * 32'h0800 +
                  ((tx_type == 3'd5) ? int'(tx_len) : 0);
              m_words.push_back(w[15:0]);
              m_words.push_back(myNodeID);
              if (tx_type == 3'd0) begin
                hops = int'(hopsFromSink) + 1;
                if (hops > 65535) hops = 65535;
                m_words.push_back(16'(hops));
                m_words.push_back(e_max);
                m_words.push_back(e_min);
                m_hdr_n = 5;
                m_phase = 2;
              end else if (tx_type == 3'd1) begin
                m_words.push_back(myQValue);
                m_words.push_back(energy);
                m_hdr_n = 4;
                m_phase = 2;
              end else begin
                m_words.push_back(tx_dest);
                for (int i = 0; i < int'(tx_len); i++)
                  m_words.push_back((i < pay_src.size()) ? pay_src[i] : 16'h0);
                m_hdr_n = 3;
                m_phase = 1;
              end
            end else begin
              m_err_exp = 1;
            end
          end
          1: if (slot_active) m_phase = 2;
          default: begin
            fire = (m_k < m_hdr_n) ? tx_ready : (pay_valid && tx_ready);
            if (fire) begin
              m_k++;
              if (m_k == total) begin
                m_phase = 0;
                m_done_exp = 1;
              end
            end
          end
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: tx_ready = ~tx_ready;
      2: tx_ready = ($urandom_range(0, 2) != 0);
      default: ;
    endcase
  endtask

  task automatic clr_mon();
    seen_q.delete();
    seen_last_q.delete();
    valid_cnt = 0; busy_cnt = 0; err_cnt = 0; done_cnt = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_phase != 0 && n < budget) begin cyc(); n++; end
    if (m_phase != 0) begin
      ntotal++;
      $display("FAIL wait_idle: packet still in flight after %0d cycles", budget);
    end
    cyc();
    cyc();
  endtask

  task automatic req(input logic [2:0] t, input logic [3:0] l);
    tx_type = t;
    tx_len  = l;
    tx_req  = 1'b1;
    cyc();
    tx_req  = 1'b0;
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen_q.size()) ? {16'h0, seen_q[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] last_mask();
    logic [31:0] m;
    m = 0;
    for (int i = 0; i < seen_last_q.size() && i < 32; i++) if (seen_last_q[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk_seq(input string name, input int n, input logic [31:0] mask);
    chk({name, "_count"}, seen_q.size(), n);
    for (int i = 0; i < n; i++) chk({name, "_word"}, seen_at(i), {16'h0, exp_w[i]});
    chk({name, "_last"}, last_mask(), mask);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_tx_data"}, tx_data, 0);
    chk({name, "_tx_valid"}, tx_valid, 0);
    chk({name, "_tx_last"}, tx_last, 0);
    chk({name, "_pay_ready"}, pay_ready, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_tx_done"}, tx_done, 0);
    chk({name, "_tx_err"}, tx_err, 0);
  endtask

  task automatic set_hb_state();
    role = 0; low_E = 0;
    myNodeID = 16'h000C; hopsFromSink = 16'd3; e_max = 16'h0100; e_min = 16'h0010;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : drv
    int n;
    nrst = 0; tx_req = 0; tx_type = 0; tx_dest = 0; tx_len = 0;
    myNodeID = 0; hopsFromSink = 0; myQValue = 0; energy = 0; e_max = 0; e_min = 0;
    role = 0; low_E = 0; slot_active = 0; tx_ready = 0;
    repeat (3) cyc();
    @(negedge clk);
    chk_outputs_zero("reset");
    cyc();
    nrst = 1;
    cyc();

    // Heartbeat with literal words; later input changes must not leak in.
    clr_mon(); rdy_mode = 0; tx_ready = 1;
    set_hb_state();
    req(3'd0, 4'd0);
    hopsFromSink = 16'h0077; e_max = 16'hAAAA; myNodeID = 16'h5555;
    wait_idle(50);
    exp_w = '{16'h0000, 16'h000C, 16'h0004, 16'h0100, 16'h0010};
    chk_seq("hb", 5, 32'b10000);
    chk("hb_done_delay", done_cyc - last_xfer_cyc, 1);
    chk("hb_done_cnt", done_cnt, 1);

    // Hop saturation under toggling backpressure.
    clr_mon(); rdy_mode = 1;
    set_hb_state(); hopsFromSink = 16'hFFFF; myNodeID = 16'h0042; e_max = 16'h0123; e_min = 16'h0045;
    req(3'd0, 4'd0);
    wait_idle(80);
    exp_w = '{16'h0000, 16'h0042, 16'hFFFF, 16'h0123, 16'h0045};
    chk_seq("hbsat", 5, 32'b10000);
    chk("hbsat_done_cnt", done_cnt, 1);

    // CH announce from a non-CH node is rejected.
    clr_mon(); rdy_mode = 0; tx_ready = 1; role = 0;
    req(3'd1, 4'd0);
    repeat (4) cyc();
    chk("ch_rej_err", err_cnt, 1);
    chk("ch_rej_valid", valid_cnt, 0);
    chk("ch_rej_busy", busy_cnt, 0);

    // CH announce from a CH node with low energy flag.
    clr_mon(); role = 1; low_E = 1; myNodeID = 16'h0005; myQValue = 16'h1234; energy = 16'h0F0F;
    req(3'd1, 4'd0);
    wait_idle(50);
    exp_w = '{16'h3800, 16'h0005, 16'h1234, 16'h0F0F, 16'h0000};
    chk_seq("ch", 4, 32'b1000);

    // Data packet held off by the slot gate, then streamed with toggling ready.
    clr_mon(); pay_src.delete(); pay_src.push_back(16'h1111); pay_src.push_back(16'h2222);
    slot_active = 0; role = 0; low_E = 0; myNodeID = 16'h000C; tx_dest = 16'hBEEF; rdy_mode = 1;
    req(3'd5, 4'd2);
    repeat (9) cyc();
    chk("gate_no_valid", valid_cnt, 0);
    chk("gate_busy", busy_cnt, 9);
    slot_active = 1;
    cyc();
    slot_active = 0;
    wait_idle(80);
    exp_w = '{16'hA002, 16'h000C, 16'hBEEF, 16'h1111, 16'h2222};
    chk_seq("data", 5, 32'b10000);
    chk("data_done_cnt", done_cnt, 1);

    // Invalid data lengths.
    rdy_mode = 0; tx_ready = 1; slot_active = 1;
    for (int k = 0; k < 2; k++) begin
      clr_mon();
      req(3'd5, (k == 0) ? 4'd0 : 4'd9);
      repeat (4) cyc();
      chk("badlen_err", err_cnt, 1);
      chk("badlen_valid", valid_cnt, 0);
      chk("badlen_busy", busy_cnt, 0);
    end

    // Reset after one payload word has gone out.
    clr_mon(); pay_src.delete();
    pay_src.push_back(16'h3333); pay_src.push_back(16'h4444); pay_src.push_back(16'h5555);
    tx_dest = 16'h0A0A;
    req(3'd5, 4'd3);
    n = 0;
    while (seen_q.size() < 4 && n < 50) begin cyc(); n++; end
    chk("rst_reach_pay", seen_q.size(), 4);
    nrst = 0; tx_ready = 0;
    cyc();
    @(negedge clk);
    chk_outputs_zero("rst_mid");
    cyc();
    nrst = 1; pay_src.delete(); tx_ready = 1;
    repeat (3) cyc();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_err", err_cnt, 0);
    clr_mon();
    set_hb_state();
    req(3'd0, 4'd0);
    wait_idle(50);
    exp_w = '{16'h0000, 16'h000C, 16'h0004, 16'h0100, 16'h0010};
    chk_seq("post_rst_hb", 5, 32'b10000);
    chk("post_rst_done", done_cnt, 1);

    // Randomized traffic against the model.
    pay_auto = 1; pay_rand = 1; rdy_mode = 2;
    for (int c = 0; c < 6000; c++) begin
      tx_req = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0, 1:    tx_type = 3'd0;
        2:       tx_type = 3'd1;
        3, 4:    tx_type = 3'd5;
        default: tx_type = 3'($urandom);
      endcase
      tx_len = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(1, MAXL));
      role = 1'($urandom); low_E = 1'($urandom);
      myNodeID = 16'($urandom); myQValue = 16'($urandom); energy = 16'($urandom);
      e_max = 16'($urandom); e_min = 16'($urandom); tx_dest = 16'($urandom);
      hopsFromSink = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      slot_active = ($urandom_range(0, 3) == 0);
      nrst = ($urandom_range(0, 799) != 0);
      cyc();
    end
    nrst = 1; tx_req = 0; slot_active = 1; rdy_mode = 0; tx_ready = 1;
    wait_idle(200);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
